// File: rtl/data_ram_pkg.sv
// Shared types and constants for the MEM-stage data RAM responder.
package data_ram_pkg;

    localparam logic [31:0] DRAM_BASE_DEFAULT = 32'h0000_0000;
    localparam int unsigned DRAM_WAIT_MAX     = 15;
    localparam int unsigned DRAM_CNT_W        = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dram_state_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dram_req_t;

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane merge: lanes with sel set come from new_word, others from old_word.
module byte_lane_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  sel,
    output logic [31:0] merged_c
);

    always_comb begin
        merged_c = old_word;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) merged_c[8*i +: 8] = new_word[8*i +: 8];
        end
    end

endmodule

// File: rtl/data_ram_responder.sv
// Data RAM responder: wait-stated word memory with byte-lane writes, range check and hold.
module data_ram_responder
    import data_ram_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned ADDR_W      = $clog2(DEPTH),
    parameter logic [31:0] BASE_ADDR   = DRAM_BASE_DEFAULT,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ram_ce_i,
    input  logic        ram_we_i,
    input  logic [3:0]  ram_sel_i,
    input  logic [31:0] ram_addr_i,
    input  logic [31:0] ram_wdata_i,
    input  logic        hold_i,
    output logic [31:0] ram_data_o,
    output logic        stall_o,
    output logic        addr_err_o
);

    dram_state_e            state_q, state_d;
    logic [DRAM_CNT_W-1:0]  cnt_q, cnt_d;
    dram_req_t              req_in, req_q, act;
    logic [ADDR_W-1:0]      idx;
    logic                   in_range;
    logic                   commit;
    logic [31:0]            old_word, merged;
    logic [31:0]            mem [DEPTH];

    assign req_in = '{we: ram_we_i, sel: ram_sel_i, addr: ram_addr_i, wdata: ram_wdata_i};

    // In IDLE the request is being latched this edge, so act on the live inputs.
    assign act      = (state_q == IDLE) ? req_in : req_q;
    assign idx      = act.addr[ADDR_W+1:2];
    assign in_range = (act.addr >> (ADDR_W + 2)) == (BASE_ADDR >> (ADDR_W + 2));
    assign old_word = mem[idx];

    byte_lane_merge u_merge (
        .old_word (old_word),
        .new_word (act.wdata),
        .sel      (act.sel),
        .merged_c (merged)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, wait counter and stall request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (ram_ce_i) begin
                    stall_o = rst_n_i;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = DRAM_CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (cnt_q != '0) cnt_d = cnt_q - DRAM_CNT_W'(1);
                else             state_d = RESP;
            end
            RESP: begin
                if (!hold_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign commit = rst_n_i && (state_q != RESP) && (state_d == RESP);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_q      <= '0;
            ram_data_o <= '0;
            addr_err_o <= 1'b0;
        end else begin
            if (state_q == IDLE && ram_ce_i) req_q <= req_in;
            if (commit && !act.we) ram_data_o <= in_range ? old_word : 32'h0;
            addr_err_o <= commit && !in_range;
        end
    end

    // Array has no reset; its contents survive a pipeline reset.
    always_ff @(posedge clk_i) begin
        if (commit && act.we && in_range) mem[idx] <= merged;
    end

endmodule
